// File: rtl/vga_timing_gen.sv
// Purpose : parametrised VGA timebase + linear framebuffer fetch, driving the board VGA DAC pins.
// Latency : RGB/sync/blank appear RD_LAT+1 pixel ticks after the tick that issued the read.
// Backpres: none; the framebuffer must return data a fixed RD_LAT pixel ticks after fb_rd.
//
// Ports:
//   CLOCK_50          system clock; the only clock in the block
//   reset             synchronous, active-high
//   fb_addr / fb_rd   framebuffer read address and per-pixel read strobe
//   fb_data           {R,G,B} pixel, COLOR_W bits per channel, valid RD_LAT ticks after fb_rd
//   frame_start       one-cycle pulse marking the first pixel tick of each frame
//   VGA_*             DAC clock, syncs, blank, sync-on-green and 8-bit colour channels
module vga_timing_gen #(
  parameter int PIX_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int COLOR_W  = 8,
  parameter int RD_LAT   = 2,
  parameter int ADDR_W   = 19
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  output logic [ADDR_W-1:0]      fb_addr,
  output logic                   fb_rd,
  input  logic [3*COLOR_W-1:0]   fb_data,
  output logic                   frame_start,
  output logic                   VGA_CLK,
  output logic                   VGA_HS,
  output logic                   VGA_VS,
  output logic                   VGA_BLANK_N,
  output logic                   VGA_SYNC_N,
  output logic [7:0]             VGA_R,
  output logic [7:0]             VGA_G,
  output logic [7:0]             VGA_B
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // One extra bit of headroom so the sync-end bound fits even when the back porch is zero.
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int DW = $clog2(PIX_DIV + 1);

  localparam logic [DW-1:0] DIV_LAST   = DW'(PIX_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF   = DW'(PIX_DIV / 2);
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] HS_BEG     = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VS_BEG     = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic          HS_ON      = (HS_POL != 0);
  localparam logic          VS_ON      = (VS_POL != 0);

  // Timebase state
  logic [DW-1:0]     div_q, div_d;
  logic [HW-1:0]     h_q, h_d;
  logic [VW-1:0]     v_q, v_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // Output stage registers
  logic       frame_start_q;
  logic       vga_clk_q, vga_clk_d;
  logic       hs_q, vs_q, blank_n_q;
  logic [7:0] r_q, g_q, b_q;

  logic       pix_ce, h_wrap, v_wrap, last_px;
  logic       act_raw, hs_raw, vs_raw;
  logic       act_dly, hs_dly, vs_dly;
  logic [7:0] r8, g8, b8;

  always_comb begin
    pix_ce  = (div_q == DIV_LAST);
    h_wrap  = (h_q == H_LAST);
    v_wrap  = (v_q == V_LAST);
    act_raw = (h_q < H_ACT) && (v_q < V_ACT);
    hs_raw  = (h_q >= HS_BEG) && (h_q < HS_END);
    vs_raw  = (v_q >= VS_BEG) && (v_q < VS_END);
    last_px = (h_q == H_ACT_LAST) && (v_q == V_ACT_LAST);

    div_d  = pix_ce ? '0 : div_q + DW'(1);
    h_d    = h_q;
    v_d    = v_q;
    addr_d = addr_q;
    if (pix_ce) begin
      h_d = h_wrap ? '0 : h_q + HW'(1);
      if (h_wrap) begin
        v_d = v_wrap ? '0 : v_q + VW'(1);
      end
      // Address follows the raster incrementally; it returns to 0 straight after the
      // last visible pixel, so it idles at 0 through the vertical blanking interval.
      if (act_raw) begin
        addr_d = last_px ? '0 : addr_q + ADDR_W'(1);
      end
    end

    // DAC latches on the rising edge of VGA_CLK, roughly mid-pixel. With no divider there
    // is no mid-pixel point, so VGA_CLK is parked high.
    vga_clk_d = (PIX_DIV == 1) || (div_d >= DIV_HALF);

    // MSB-align each colour channel into 8 bits.
    r8 = 8'(fb_data[3*COLOR_W-1 -: COLOR_W]) << (8 - COLOR_W);
    g8 = 8'(fb_data[2*COLOR_W-1 -: COLOR_W]) << (8 - COLOR_W);
    b8 = 8'(fb_data[COLOR_W-1 -: COLOR_W])   << (8 - COLOR_W);
  end

  // Sync/blank delay line, matched to the framebuffer read latency.
  generate
    if (RD_LAT == 0) begin : g_nodly
      always_comb begin
        act_dly = act_raw;
        hs_dly  = hs_raw;
        vs_dly  = vs_raw;
      end
    end else begin : g_dly
      logic [RD_LAT-1:0] act_pipe_q, hs_pipe_q, vs_pipe_q;

      always_ff @(posedge CLOCK_50) begin
        if (reset) begin
          act_pipe_q <= '0;
          hs_pipe_q  <= '0;
          vs_pipe_q  <= '0;
        end else if (pix_ce) begin
          act_pipe_q[0] <= act_raw;
          hs_pipe_q[0]  <= hs_raw;
          vs_pipe_q[0]  <= vs_raw;
          for (int i = 1; i < RD_LAT; i++) begin
            act_pipe_q[i] <= act_pipe_q[i-1];
            hs_pipe_q[i]  <= hs_pipe_q[i-1];
            vs_pipe_q[i]  <= vs_pipe_q[i-1];
          end
        end
      end

      always_comb begin
        act_dly = act_pipe_q[RD_LAT-1];
        hs_dly  = hs_pipe_q[RD_LAT-1];
        vs_dly  = vs_pipe_q[RD_LAT-1];
      end
    end
  endgenerate

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      div_q         <= '0;
      h_q           <= '0;
      v_q           <= '0;
      addr_q        <= '0;
      frame_start_q <= 1'b0;
      vga_clk_q     <= 1'b0;
      hs_q          <= ~HS_ON;
      vs_q          <= ~VS_ON;
      blank_n_q     <= 1'b0;
      r_q           <= 8'h00;
      g_q           <= 8'h00;
      b_q           <= 8'h00;
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      addr_q        <= addr_d;
      // Registered, so the pulse trails the (h=0,v=0) pixel tick by one CLOCK_50.
      frame_start_q <= pix_ce && (h_q == '0) && (v_q == '0);
      vga_clk_q     <= vga_clk_d;
      // Output stage moves only on pixel ticks so syncs, blank and colour change together.
      if (pix_ce) begin
        hs_q      <= hs_dly ? HS_ON : ~HS_ON;
        vs_q      <= vs_dly ? VS_ON : ~VS_ON;
        blank_n_q <= act_dly;
        r_q       <= act_dly ? r8 : 8'h00;
        g_q       <= act_dly ? g8 : 8'h00;
        b_q       <= act_dly ? b8 : 8'h00;
      end
    end
  end

  assign fb_addr     = addr_q;
  assign fb_rd       = pix_ce & act_raw;
  assign frame_start = frame_start_q;
  assign VGA_CLK     = vga_clk_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance, a tiny-mode instance fed by a
// RAM model that returns data == address, and a tiny-mode instance with active-high
// syncs and 4-bit colour on a constant pixel.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_d, rst_s;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  // Default-mode instance
  logic [18:0] d_addr;
  logic        d_rd, d_fs, d_clk, d_hs, d_vs, d_bn, d_sn;
  logic [7:0]  d_r, d_g, d_b;
  logic [23:0] d_data;
  assign d_data = 24'hA53C0F;

  vga_timing_gen u_def (
    .CLOCK_50(clk), .reset(rst_d), .fb_addr(d_addr), .fb_rd(d_rd), .fb_data(d_data),
    .frame_start(d_fs), .VGA_CLK(d_clk), .VGA_HS(d_hs), .VGA_VS(d_vs),
    .VGA_BLANK_N(d_bn), .VGA_SYNC_N(d_sn), .VGA_R(d_r), .VGA_G(d_g), .VGA_B(d_b)
  );

  // Small mode: 8/2/2/2 x 4/1/1/1, 14 ticks per line, 98 ticks (196 clocks) per frame
  logic [5:0]  s_addr;
  logic        s_rd, s_fs, s_clk, s_hs, s_vs, s_bn, s_sn;
  logic [7:0]  s_r, s_g, s_b;
  logic [23:0] s_data;
  logic [5:0]  mem_q [0:3];

  // RAM model: 2 pixel ticks = 4 CLOCK_50 cycles of read latency, data equals address.
  always @(posedge clk) begin
    mem_q[0] <= s_addr;
    mem_q[1] <= mem_q[0];
    mem_q[2] <= mem_q[1];
    mem_q[3] <= mem_q[2];
  end
  assign s_data = {18'd0, mem_q[3]};

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .RD_LAT(2), .ADDR_W(6)
  ) u_sml (
    .CLOCK_50(clk), .reset(rst_s), .fb_addr(s_addr), .fb_rd(s_rd), .fb_data(s_data),
    .frame_start(s_fs), .VGA_CLK(s_clk), .VGA_HS(s_hs), .VGA_VS(s_vs),
    .VGA_BLANK_N(s_bn), .VGA_SYNC_N(s_sn), .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b)
  );

  // Small mode, active-high syncs, 4-bit colour, constant pixel
  logic [5:0]  p_addr;
  logic        p_rd, p_fs, p_clk, p_hs, p_vs, p_bn, p_sn;
  logic [7:0]  p_r, p_g, p_b;
  logic [11:0] p_data;
  assign p_data = 12'hF81;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1), .VS_POL(1), .COLOR_W(4), .RD_LAT(2), .ADDR_W(6)
  ) u_pol (
    .CLOCK_50(clk), .reset(rst_s), .fb_addr(p_addr), .fb_rd(p_rd), .fb_data(p_data),
    .frame_start(p_fs), .VGA_CLK(p_clk), .VGA_HS(p_hs), .VGA_VS(p_vs),
    .VGA_BLANK_N(p_bn), .VGA_SYNC_N(p_sn), .VGA_R(p_r), .VGA_G(p_g), .VGA_B(p_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Measurement variables
  int hs_low, bn_high, rd_cnt, rgb_bad, fall1, fall2, run1, fin_addr, fin_rd;
  int px_cnt, px_bad, exp_px, rd_bad, rd_exp, fs_cnt, fs_2nd, vs_low, s_fall1, s_fall2, s_run;
  int p_hs_hi, p_vs_hi, p_bn_hi, p_bad, found;
  logic prev_hs, prev_shs;

  initial begin
    rst_d = 1'b1;
    rst_s = 1'b1;
    repeat (10) @(negedge clk);

    // Reset state
    check("rst_hs", 32'(d_hs), 32'd1);
    check("rst_vs", 32'(d_vs), 32'd1);
    check("rst_blank", 32'(d_bn), 32'd0);
    check("rst_rgb", 32'({d_r, d_g, d_b}), 32'd0);
    check("rst_fb_rd", 32'(d_rd), 32'd0);
    check("rst_fb_addr", 32'(d_addr), 32'd0);
    check("rst_frame_start", 32'(d_fs), 32'd0);
    check("rst_vga_clk", 32'(d_clk), 32'd0);
    check("sync_n", 32'(d_sn), 32'd0);
    check("pol_rst_hs", 32'(p_hs), 32'd0);
    check("pol_rst_vs", 32'(p_vs), 32'd0);

    // Release: first pixel tick one cycle later, frame_start registered one cycle after that
    rst_d = 1'b0;
    rst_s = 1'b0;
    @(negedge clk);
    check("fs_cycle1", 32'(d_fs), 32'd0);
    check("first_rd", 32'(d_rd), 32'd1);
    check("first_addr", 32'(d_addr), 32'd0);
    @(negedge clk);
    check("fs_cycle2", 32'(d_fs), 32'd1);

    // Default mode: two full lines (3200 CLOCK_50 cycles)
    hs_low = 0; bn_high = 0; rd_cnt = 0; rgb_bad = 0;
    fall1 = -1; fall2 = -1; run1 = 0; fin_addr = 0; fin_rd = 0;
    prev_hs = 1'b1;
    for (int i = 0; i < 3200; i++) begin
      if (!d_hs) hs_low++;
      if (d_bn) bn_high++;
      if (d_rd) rd_cnt++;
      if (d_bn && ({d_r, d_g, d_b} != 24'hA53C0F)) rgb_bad++;
      if (!d_bn && ({d_r, d_g, d_b} != 24'h000000)) rgb_bad++;
      if (prev_hs && !d_hs) begin
        if (fall1 < 0) fall1 = i;
        else if (fall2 < 0) fall2 = i;
      end
      if (!d_hs && fall1 >= 0 && fall2 < 0) run1++;
      if (i == 3199) begin
        fin_addr = int'(d_addr);
        fin_rd   = int'(d_rd);
      end
      prev_hs = d_hs;
      @(negedge clk);
    end
    check("def_hs_low_2lines", 32'(hs_low), 32'd384);
    check("def_hs_pulse", 32'(run1), 32'd192);
    check("def_line_period", 32'(fall2 - fall1), 32'd1600);
    check("def_blank_high_2lines", 32'(bn_high), 32'd2560);
    check("def_fb_rd_count", 32'(rd_cnt), 32'd1280);
    check("def_rgb_bad", 32'(rgb_bad), 32'd0);
    check("def_addr_line2", 32'(fin_addr), 32'd1280);
    check("def_rd_line2", 32'(fin_rd), 32'd1);

    // Mid-frame reset on the small instances at pixel (h=5,v=1)
    found = 0;
    for (int i = 0; i < 400 && found == 0; i++) begin
      if (s_rd && s_addr == 6'd13) found = 1;
      else @(negedge clk);
    end
    check("mid_point_found", 32'(found), 32'd1);
    rst_s = 1'b1;
    @(negedge clk);
    check("mid_rst_hs", 32'(s_hs), 32'd1);
    check("mid_rst_vs", 32'(s_vs), 32'd1);
    check("mid_rst_blank", 32'(s_bn), 32'd0);
    check("mid_rst_rgb", 32'({s_r, s_g, s_b}), 32'd0);
    check("mid_rst_rd", 32'(s_rd), 32'd0);
    check("mid_rst_addr", 32'(s_addr), 32'd0);
    check("mid_rst_vga_clk", 32'(s_clk), 32'd0);
    check("mid_rst_pol_hs", 32'(p_hs), 32'd0);
    rst_s = 1'b0;
    @(negedge clk);
    check("mid_first_rd", 32'(s_rd), 32'd1);
    check("mid_first_addr", 32'(s_addr), 32'd0);
    @(negedge clk);
    check("mid_fs", 32'(s_fs), 32'd1);

    // Small mode: two frames (392 cycles) starting at the frame_start sample
    px_cnt = 0; px_bad = 0; exp_px = 0; rd_bad = 0; rd_exp = 1; rd_cnt = 0;
    fs_cnt = 0; fs_2nd = -1; hs_low = 0; vs_low = 0; bn_high = 0;
    s_fall1 = -1; s_fall2 = -1; s_run = 0; prev_shs = 1'b1;
    p_hs_hi = 0; p_vs_hi = 0; p_bn_hi = 0; p_bad = 0;
    for (int i = 0; i < 392; i++) begin
      if (s_bn && s_clk) begin
        if ({s_r, s_g, s_b} !== 24'(exp_px)) px_bad++;
        px_cnt++;
        exp_px = (exp_px + 1) % 32;
      end
      if (!s_bn && ({s_r, s_g, s_b} != 24'h000000)) px_bad++;
      if (s_rd) begin
        if (int'(s_addr) != rd_exp) rd_bad++;
        rd_exp = (rd_exp + 1) % 32;
        rd_cnt++;
      end
      if (s_fs) begin
        fs_cnt++;
        if (i > 0 && fs_2nd < 0) fs_2nd = i;
      end
      if (!s_hs) hs_low++;
      if (!s_vs) vs_low++;
      if (s_bn && i < 196) bn_high++;
      if (prev_shs && !s_hs) begin
        if (s_fall1 < 0) s_fall1 = i;
        else if (s_fall2 < 0) s_fall2 = i;
      end
      if (!s_hs && s_fall1 >= 0 && s_fall2 < 0) s_run++;
      prev_shs = s_hs;
      if (p_hs) p_hs_hi++;
      if (p_vs) p_vs_hi++;
      if (p_bn) p_bn_hi++;
      if (p_bn && ({p_r, p_g, p_b} != 24'hF08010)) p_bad++;
      if (!p_bn && ({p_r, p_g, p_b} != 24'h000000)) p_bad++;
      @(negedge clk);
    end
    check("sml_pixel_count", 32'(px_cnt), 32'd64);
    check("sml_pixel_bad", 32'(px_bad), 32'd0);
    check("sml_rd_count", 32'(rd_cnt), 32'd64);
    check("sml_rd_addr_bad", 32'(rd_bad), 32'd0);
    check("sml_fs_count", 32'(fs_cnt), 32'd2);
    check("sml_frame_period", 32'(fs_2nd), 32'd196);
    check("sml_blank_high_frame", 32'(bn_high), 32'd64);
    check("sml_hs_low", 32'(hs_low), 32'd56);
    check("sml_hs_pulse", 32'(s_run), 32'd4);
    check("sml_line_period", 32'(s_fall2 - s_fall1), 32'd28);
    check("sml_vs_low", 32'(vs_low), 32'd56);
    check("pol_hs_high", 32'(p_hs_hi), 32'd56);
    check("pol_vs_high", 32'(p_vs_hi), 32'd56);
    check("pol_blank_high", 32'(p_bn_hi), 32'd128);
    check("pol_rgb_bad", 32'(p_bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
